// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: redirect/stall controls, instruction ROM port and IF/ID register outputs.
// master = fetch unit, slave = surrounding pipeline / ROM.
interface instruction_fetch_unit_if;
  logic        i_stall;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_target;
  logic [31:0] i_instruction;
  logic [31:0] o_address;
  logic [31:0] o_ifid_instruction;
  logic [31:0] o_ifid_pc;
  logic [31:0] o_ifid_pc_plus4;
  logic        o_ifid_valid;
  logic        o_ifid_early_jump;
  logic        o_align_error;
  logic [31:0] o_fetch_count;

  modport master (
    input  i_stall, i_redirect_valid, i_redirect_target, i_instruction,
    output o_address, o_ifid_instruction, o_ifid_pc, o_ifid_pc_plus4,
           o_ifid_valid, o_ifid_early_jump, o_align_error, o_fetch_count
  );

  modport slave (
    output i_stall, i_redirect_valid, i_redirect_target, i_instruction,
    input  o_address, o_ifid_instruction, o_ifid_pc, o_ifid_pc_plus4,
           o_ifid_valid, o_ifid_early_jump, o_align_error, o_fetch_count
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: PC register, IF/ID pipeline register, redirect/stall/flush and fetch counter.
// Optional macro FETCH_EARLY_JUMP_EN resolves J/JAL in fetch instead of waiting for a redirect.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0040_0000,
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  instruction_fetch_unit_if.master  bus
);
  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_ifid_instruction;
  logic [XLEN-1:0] r_ifid_pc;
  logic [XLEN-1:0] r_ifid_pc_plus4;
  logic            r_ifid_valid;
  logic            r_ifid_early_jump;
  logic            r_align_error;
  logic [XLEN-1:0] r_fetch_count;

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_redirect_pc;
  logic [XLEN-1:0] w_seq_pc;
  logic            w_is_jump;

  assign w_pc_plus4    = r_pc + XLEN'(4);
  assign w_redirect_pc = {bus.i_redirect_target[XLEN-1:2], 2'b00};

`ifdef FETCH_EARLY_JUMP_EN
  // J (000010) and JAL (000011) differ only in opcode bit 26.
  assign w_is_jump = (bus.i_instruction[31:27] == 5'b00001);
  assign w_seq_pc  = w_is_jump ? {w_pc_plus4[31:28], bus.i_instruction[25:0], 2'b00}
                               : w_pc_plus4;
`else
  assign w_is_jump = 1'b0;
  assign w_seq_pc  = w_pc_plus4;
`endif

  // Priority: redirect > stall > sequential/early-jump fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc               <= RESET_PC;
      r_ifid_instruction <= BUBBLE_INSTR;
      r_ifid_pc          <= '0;
      r_ifid_pc_plus4    <= '0;
      r_ifid_valid       <= 1'b0;
      r_ifid_early_jump  <= 1'b0;
      r_align_error      <= 1'b0;
      r_fetch_count      <= '0;
    end else if (bus.i_redirect_valid) begin
      r_pc               <= w_redirect_pc;
      r_ifid_instruction <= BUBBLE_INSTR;
      r_ifid_valid       <= 1'b0;
      r_ifid_early_jump  <= 1'b0;
      r_align_error      <= |bus.i_redirect_target[1:0];
    end else if (bus.i_stall) begin
      r_align_error      <= 1'b0;
    end else begin
      r_pc               <= w_seq_pc;
      r_ifid_instruction <= bus.i_instruction;
      r_ifid_pc          <= r_pc;
      r_ifid_pc_plus4    <= w_pc_plus4;
      r_ifid_valid       <= 1'b1;
      r_ifid_early_jump  <= w_is_jump;
      r_align_error      <= 1'b0;
      r_fetch_count      <= r_fetch_count + XLEN'(1);
    end
  end

  assign bus.o_address          = r_pc;
  assign bus.o_ifid_instruction = r_ifid_instruction;
  assign bus.o_ifid_pc          = r_ifid_pc;
  assign bus.o_ifid_pc_plus4    = r_ifid_pc_plus4;
  assign bus.o_ifid_valid       = r_ifid_valid;
  assign bus.o_ifid_early_jump  = r_ifid_early_jump;
  assign bus.o_align_error      = r_align_error;
  assign bus.o_fetch_count      = r_fetch_count;
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage of the single-issue MIPS pipeline.
- Holds the program counter and drives the fetch address to the combinational instruction ROM.
- Captures the returned instruction word into the IF/ID pipeline register for decode.
- Handles stall, redirect (branch, jr or jump resolved downstream) and flush, and keeps a count of issued fetches.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- BUBBLE_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on flush (nop).

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- Stall  input  1  hold PC and IF/ID (load-use hazard from decode).
- RedirectValid  input  1  branch/jump resolved downstream; load RedirectTarget.
- RedirectTarget  input  32  new PC on redirect.
- Address  output  32  current PC to instruction ROM.
- Instruction  input  32  ROM data for Address (combinational, same cycle).
- IfIdInstruction  output  32  registered instruction to decode.
- IfIdPc  output  32  PC of IfIdInstruction.
- IfIdPcPlus4  output  32  IfIdPc + 4.
- IfIdValid  output  1  IF/ID holds a real instruction.
- IfIdEarlyJump  output  1  instruction already redirected by fetch (optional feature; 0 when disabled).
- AlignError  output  1  one-cycle pulse when RedirectTarget[1:0] != 0.
- FetchCount  output  32  number of instructions issued into IF/ID.

Behaviour:
- Address = PC. All arithmetic is modulo 2^32. PC+4 from 32'hFFFF_FFFC wraps to 0.
- Reset (async, any time, including mid-redirect or mid-stall) sets:
  - PC=RESET_PC
  - IfIdInstruction=BUBBLE_INSTR, IfIdPc=0, IfIdPcPlus4=0
  - IfIdValid=0, IfIdEarlyJump=0
  - AlignError=0, FetchCount=0
- Per-edge priority, highest first:
  1. REDIRECT (RedirectValid=1)
     - PC <= {RedirectTarget[31:2],2'b00}.
     - IF/ID flushed: IfIdInstruction=BUBBLE_INSTR, IfIdValid=0, IfIdEarlyJump=0, IfIdPc/IfIdPcPlus4 hold.
     - AlignError <= |RedirectTarget[1:0].
     - FetchCount unchanged.
     - Redirect overrides a simultaneous Stall.
  2. STALL (Stall=1, no redirect)
     - PC and all IF/ID outputs hold. FetchCount holds. AlignError <= 0.
  3. EARLY JUMP (only with the optional feature)
     - See Optional Feature.
  4. NORMAL
     - PC <= PC+4.
     - IfIdInstruction <= Instruction, IfIdPc <= PC, IfIdPcPlus4 <= PC+4, IfIdValid <= 1, IfIdEarlyJump <= 0.
     - FetchCount <= FetchCount+1 (wraps at 2^32).
     - AlignError <= 0.
- Latency:
  - Instruction at PC appears on IfIdInstruction the edge after PC is presented.
  - Redirect penalty is one bubble: the IF/ID entry captured on the redirect edge is invalid.
- Consecutive stalls hold indefinitely. Releasing Stall resumes with the held PC; no instruction is lost or duplicated.
- Redirect to the current PC is legal: the instruction is refetched and a bubble is inserted.

Optional Feature:
- Macro: FETCH_EARLY_JUMP_EN.
- Defined:
  - In the NORMAL case, if Instruction[31:26]==6'b000010 (J) or 6'b000011 (JAL), PC <= {PC_plus4[31:28], Instruction[25:0], 2'b00} instead of PC+4.
  - IF/ID captures the jump as normal with IfIdEarlyJump=1, so decode does not redirect again.
  - FetchCount increments.
  - Stall and Redirect still take priority.
- Undefined:
  - No opcode inspection; jumps are resolved only via RedirectValid.
  - IfIdEarlyJump is tied to 0.

Test Plan:
- Reset, release, ROM word0=32'h24020008, word1=32'h2403000C -> Address=32'h00400000. After edge 1: IfIdInstruction=32'h24020008, IfIdPc=32'h00400000, IfIdPcPlus4=32'h00400004, IfIdValid=1, Address=32'h00400004, FetchCount=1.
- Stall=1 for 3 cycles after edge 2 -> Address stays 32'h00400008, IF/ID holds 32'h2403000C, FetchCount stays 2. Release -> next edge captures word2 at 32'h00400008.
- RedirectValid=1, RedirectTarget=32'h00400014, with Stall=1 the same cycle -> next edge: Address=32'h00400014, IfIdValid=0, IfIdInstruction=0, FetchCount unchanged, AlignError=0.
- RedirectTarget=32'h00400016 -> Address=32'h00400014, AlignError=1 for exactly one cycle.
- FETCH_EARLY_JUMP_EN defined, Instruction=32'h08100005 at PC 32'h00400048 -> next Address=32'h00400014, IfIdEarlyJump=1, IfIdValid=1. Macro undefined -> next Address=32'h0040004C, IfIdEarlyJump=0.
- Assert Reset asynchronously mid-cycle during a redirect -> outputs return to reset values immediately, without waiting for a clock edge. First fetch after release is at 32'h00400000.
